decoder_rr_arbiter: RTL

- Round-robin arbiter that shares the 3-to-8 decoder (3-bit iData, 2-bit iEna, 8-bit oData) between 8 requesters.
- Selects one requester and drives its index and the decoder enable code. The decoder's oData then serves as the one-hot select/grant strobe.
- Also presents its own registered one-hot grant and status.
- Sits between the requester bank and the decoder instance.

---
 rtl/decoder_rr_arbiter_pkg.sv | 22 ++
 rtl/decoder_rr_arbiter_rr_pick.sv | 40 ++++
 rtl/decoder_rr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin decoder arbiter.
package decoder_arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    // Decoder enable codes: only 2'b10 lets the decoder drive its outputs.
    localparam logic [1:0] ENA_ON  = 2'b10;
    localparam logic [1:0] ENA_OFF = 2'b11;

    // One-hot vector with only bit idx set.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
    import decoder_arb_pkg::*;
(
    input  logic [NREQ-1:0]  iReq,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [NREQ-1:0]  rotated;
    logic [IDX_W-1:0] first;

    // Rotate right by ptr so that requester ptr lands on bit 0.
    always_comb begin
        rotated = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            rotated[i] = iReq[IDX_W'(i) + ptr];
        end
    end

    // Fixed-priority encode of the rotated vector, lowest bit wins.
    always_comb begin
        first = {IDX_W{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                first = IDX_W'(i);
            end else begin
                first = first;
            end
        end
    end

    // Undo the rotation; the 3-bit add wraps naturally modulo 8.
    always_comb begin
        pick = first + ptr;
        any  = |iReq;
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 decoder (index + enable code),
// with break-before-make GAP cycle and optional hold-time limit.
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  iReq,
    input  logic             iDone,
    output logic [IDX_W-1:0] oData,
    output logic [1:0]       oEna,
    output logic [NREQ-1:0]  oGrant,
    output logic             oBusy,
    output logic             oTimeout
);

    localparam bit               LIMIT_EN  = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;
    logic [HOLD_W-1:0] hold, hold_nx;
    logic [IDX_W-1:0] data_nx;
    logic [1:0]       ena_nx;
    logic [NREQ-1:0]  grant_nx;
    logic             busy_nx;
    logic             timeout_nx;

    logic [IDX_W-1:0] pick;
    logic             any;
    logic             hold_limit;
    logic             owner_req;
    logic             release_now;

    rr_pick u_pick (
        .iReq (iReq),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    // Release conditions for the current owner; coincident events merge into one.
    always_comb begin
        hold_limit  = LIMIT_EN && (hold == HOLD_LAST);
        owner_req   = iReq[oData];
        release_now = iDone || !owner_req || hold_limit;
    end

    // Next-state and next-output logic; registers hold their value by default.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        hold_nx    = hold;
        data_nx    = oData;
        ena_nx     = oEna;
        grant_nx   = oGrant;
        busy_nx    = oBusy;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nx = GRANT;
                    data_nx  = pick;
                    ena_nx   = ENA_ON;
                    grant_nx = idx_to_onehot(pick);
                    busy_nx  = 1'b1;
                    hold_nx  = {HOLD_W{1'b0}};
                end else begin
                    ena_nx   = ENA_OFF;
                    grant_nx = {NREQ{1'b0}};
                    busy_nx  = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // Decoder is disabled first; the index stays for observability.
                    state_nx   = GAP;
                    ena_nx     = ENA_OFF;
                    grant_nx   = {NREQ{1'b0}};
                    busy_nx    = 1'b0;
                    ptr_nx     = oData + 3'd1;
                    hold_nx    = {HOLD_W{1'b0}};
                    timeout_nx = hold_limit && !iDone && owner_req;
                end else begin
                    hold_nx = (hold == HOLD_SAT) ? hold : (hold + HOLD_ONE);
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                ena_nx   = ENA_OFF;
                grant_nx = {NREQ{1'b0}};
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State, pointer, hold counter and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= {IDX_W{1'b0}};
            hold     <= {HOLD_W{1'b0}};
            oData    <= {IDX_W{1'b0}};
            oEna     <= ENA_OFF;
            oGrant   <= {NREQ{1'b0}};
            oBusy    <= 1'b0;
            oTimeout <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold     <= hold_nx;
            oData    <= data_nx;
            oEna     <= ena_nx;
            oGrant   <= grant_nx;
            oBusy    <= busy_nx;
            oTimeout <= timeout_nx;
        end
    end

endmodule
